// File: rtl/i2si_bist_gen_mc.sv
// i2si_bist_gen_mc: multi-channel BIST pattern source (saw/tri/square) for the I2S RX path.
// Define I2SI_BIST_LFSR_EN to build mode 11 as a Galois LFSR; otherwise it emits start_val.
module i2si_bist_gen_mc #(
  parameter int DATA_W = 32,
  parameter int INC_W = 8,
  parameter int SLOT_BITS = 32,
  parameter int CH = 2,
`ifdef I2SI_BIST_LFSR_EN
  parameter logic [DATA_W-1:0] LFSR_POLY = 32'h80200003,
`endif
  parameter int CH_W = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sck_transition,
  input  logic              rf_bist_en,
  input  logic [1:0]        rf_bist_mode,
  input  logic [DATA_W-1:0] rf_bist_start_val,
  input  logic [DATA_W-1:0] rf_bist_up_limit,
  input  logic [INC_W-1:0]  rf_bist_inc,
  input  logic [DATA_W-1:0] rf_bist_ch_offset,
  output logic [DATA_W-1:0] i2si_bist_out_data,
  output logic [CH_W-1:0]   i2si_bist_out_ch,
  output logic              i2si_bist_out_xfc,
  output logic              i2si_bist_wrap
);

  localparam int CNT_W = $clog2(SLOT_BITS);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SLOT_BITS - 1);
  localparam logic [CH_W-1:0] CH_MAX = CH_W'(CH - 1);

  typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;
  state_t state, state_nx;

  logic [CNT_W-1:0] sck_cnt;
  logic [CH_W-1:0] ch_idx, ch_nx;
  logic [DATA_W-1:0] p, p_nx, p_st, off_q, seed, incx, data_nx;
  logic [1:0] mode_q;
  logic dir, dir_nx, dir_st;
  logic [INC_W-1:0] hold, hold_nx, hold_st, half;
  logic xfc_nx, wrap_nx, wrap_st;
  logic slot_end, frame_end;
  logic [DATA_W:0] sum, dif;

  assign slot_end = sck_transition && (sck_cnt == CNT_MAX);
  assign frame_end = slot_end && (ch_idx == CH_MAX);
  assign ch_nx = (ch_idx == CH_MAX) ? '0 : ch_idx + 1'b1;
  assign incx = DATA_W'(rf_bist_inc);
  assign sum = {1'b0, p} + {1'b0, incx};
  assign dif = {1'b0, p} - {1'b0, incx};
  assign half = (rf_bist_inc == '0) ? '0 : rf_bist_inc - 1'b1;

`ifdef I2SI_BIST_LFSR_EN
  assign seed = (rf_bist_mode == 2'b11 && rf_bist_start_val == '0)
              ? DATA_W'(1) : rf_bist_start_val;
`else
  assign seed = rf_bist_start_val;
`endif

  // One frame step of the running pattern; dir doubles as square phase.
  always_comb begin
    p_st = p;
    dir_st = dir;
    hold_st = '0;
    wrap_st = 1'b0;
    unique case (rf_bist_mode)
      2'b00: begin
        if (rf_bist_inc == '0 || p >= rf_bist_up_limit || sum[DATA_W]) begin
          p_st = rf_bist_start_val;
          wrap_st = 1'b1;
        end else p_st = sum[DATA_W-1:0];
      end
      2'b01: begin
        if (rf_bist_inc == '0 || rf_bist_start_val >= rf_bist_up_limit) begin
          p_st = rf_bist_start_val;
          dir_st = 1'b0;
        end else if (!dir) begin
          if (sum[DATA_W] || sum[DATA_W-1:0] >= rf_bist_up_limit) begin
            p_st = rf_bist_up_limit;
            dir_st = 1'b1;
          end else p_st = sum[DATA_W-1:0];
        end else if (dif[DATA_W] || dif[DATA_W-1:0] <= rf_bist_start_val) begin
          p_st = rf_bist_start_val;
          dir_st = 1'b0;
          wrap_st = 1'b1;
        end else p_st = dif[DATA_W-1:0];
      end
      2'b10: begin
        if (hold >= half) begin
          dir_st = !dir;
          p_st = dir ? rf_bist_start_val : rf_bist_up_limit;
          wrap_st = dir;
        end else hold_st = hold + 1'b1;
      end
      2'b11: begin
`ifdef I2SI_BIST_LFSR_EN
        p_st = (p >> 1) ^ (p[0] ? LFSR_POLY : '0);
`else
        p_st = rf_bist_start_val;
`endif
      end
    endcase
  end

  always_comb begin
    state_nx = state;
    p_nx = p;
    dir_nx = dir;
    hold_nx = hold;
    data_nx = i2si_bist_out_data;
    xfc_nx = 1'b0;
    wrap_nx = 1'b0;
    unique case (state)
      IDLE: if (rf_bist_en) state_nx = ARM;
      ARM: begin
        if (!rf_bist_en) state_nx = IDLE;
        else if (frame_end) begin
          state_nx = RUN;
          p_nx = seed;
          dir_nx = 1'b0;
          hold_nx = '0;
          data_nx = seed;
          xfc_nx = 1'b1;
        end
      end
      RUN: begin
        if (!rf_bist_en) state_nx = IDLE;
        else if (frame_end) begin
          if (rf_bist_mode != mode_q) begin
            p_nx = seed;
            dir_nx = 1'b0;
            hold_nx = '0;
            wrap_nx = (rf_bist_mode != 2'b11);
          end else begin
            p_nx = p_st;
            dir_nx = dir_st;
            hold_nx = hold_st;
            wrap_nx = wrap_st;
          end
          data_nx = p_nx;
          xfc_nx = 1'b1;
        end else if (slot_end) begin
          data_nx = p + DATA_W'(ch_nx) * off_q;
          xfc_nx = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      sck_cnt <= CNT_MAX;
      ch_idx <= CH_MAX;
      p <= '0;
      dir <= 1'b0;
      hold <= '0;
      mode_q <= '0;
      off_q <= '0;
      i2si_bist_out_data <= '0;
      i2si_bist_out_ch <= '0;
      i2si_bist_out_xfc <= 1'b0;
      i2si_bist_wrap <= 1'b0;
    end else begin
      state <= state_nx;
      p <= p_nx;
      dir <= dir_nx;
      hold <= hold_nx;
      i2si_bist_out_data <= data_nx;
      i2si_bist_out_xfc <= xfc_nx;
      i2si_bist_wrap <= wrap_nx;
      if (sck_transition) sck_cnt <= sck_cnt + 1'b1;
      if (slot_end) ch_idx <= ch_nx;
      if (xfc_nx) i2si_bist_out_ch <= ch_nx;
      if (frame_end) begin
        mode_q <= rf_bist_mode;
        off_q <= rf_bist_ch_offset;
      end
    end
  end

endmodule
